// File: rtl/div_restoring_seq_pkg.sv
// Shared definitions for the sequential restoring divider: FSM encoding and
// counter sizing derived from the operand width.
package div_restoring_seq_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } div_state_e;

  // Counter must hold WIDTH itself so that it never wraps.
  function automatic int cnt_width(input int width);
    return $clog2(width + 1);
  endfunction

endpackage

// File: rtl/div_trial_sub.sv
// Combinational subtract-mode trial: diff = minuend - subtrahend, with the
// carry-out reported as no_borrow (1 when minuend >= subtrahend).
module div_trial_sub #(
  parameter int WIDTH = 4
) (
  input  logic [WIDTH-1:0] in_minuend,
  input  logic [WIDTH-1:0] in_subtrahend,
  output logic [WIDTH-1:0] out_diff,
  output logic             out_no_borrow
);

  logic [WIDTH:0] sum_s;

  // Two's-complement subtract as minuend + ~subtrahend + 1; the extra bit is the carry-out.
  always_comb begin
    sum_s = {1'b0, in_minuend} + {1'b0, ~in_subtrahend} + {{WIDTH{1'b0}}, 1'b1};
  end

  assign out_diff      = sum_s[WIDTH-1:0];
  assign out_no_borrow = sum_s[WIDTH];

endmodule

// File: rtl/div_restoring_seq.sv
// Sequential unsigned restoring divider: one shift/trial-subtract per clock,
// start/done handshake, registered results held until the next accepted start.
module div_restoring_seq
  import div_restoring_seq_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic             in_clk,
  input  logic             in_rst_n,
  input  logic             in_start,
  input  logic [WIDTH-1:0] in_dividend,
  input  logic [WIDTH-1:0] in_divisor,
  output logic             out_busy,
  output logic             out_done,
  output logic [WIDTH-1:0] out_quotient,
  output logic [WIDTH-1:0] out_remainder,
  output logic             out_div_by_zero
);

  localparam int CNT_W = cnt_width(WIDTH);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

  div_state_e       state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] q_q, q_d;
  logic [WIDTH-1:0] d_q, d_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] quot_q, quot_d;
  logic [WIDTH-1:0] rem_q, rem_d;
  logic             dbz_q, dbz_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;

  logic [WIDTH:0]   p_s;
  logic [WIDTH-1:0] diff_s;
  logic             no_borrow_s;
  logic             ge_s;

  assign p_s  = {a_q, q_q[WIDTH-1]};
  assign ge_s = p_s[WIDTH] | no_borrow_s;

  div_trial_sub #(.WIDTH(WIDTH)) u_trial (
    .in_minuend    (p_s[WIDTH-1:0]),
    .in_subtrahend (d_q),
    .out_diff      (diff_s),
    .out_no_borrow (no_borrow_s)
  );

  // Next-state and datapath update for the IDLE/RUN/DONE sequence.
  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    q_d     = q_q;
    d_d     = d_q;
    cnt_d   = cnt_q;
    quot_d  = quot_q;
    rem_d   = rem_q;
    dbz_d   = dbz_q;
    case (state_q)
      ST_IDLE: begin
        if (in_start) begin
          if (in_divisor != {WIDTH{1'b0}}) begin
            state_d = ST_RUN;
            a_d     = {WIDTH{1'b0}};
            q_d     = in_dividend;
            d_d     = in_divisor;
            cnt_d   = {CNT_W{1'b0}};
          end else begin
            state_d = ST_DONE;
            quot_d  = {WIDTH{1'b1}};
            rem_d   = in_dividend;
            dbz_d   = 1'b1;
          end
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_RUN: begin
        a_d   = ge_s ? diff_s : p_s[WIDTH-1:0];
        q_d   = {q_q[WIDTH-2:0], ge_s};
        cnt_d = cnt_q + CNT_W'(1);
        // Results publish on the final trial edge, so they use this edge's values.
        if (cnt_q == LAST_CNT) begin
          state_d = ST_DONE;
          quot_d  = q_d;
          rem_d   = a_d;
          dbz_d   = 1'b0;
        end else begin
          state_d = ST_RUN;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
    busy_d = (state_d != ST_IDLE);
    done_d = (state_d == ST_DONE);
  end

  // State and result registers; reset clears everything immediately.
  always_ff @(posedge in_clk or negedge in_rst_n) begin
    if (!in_rst_n) begin
      state_q <= ST_IDLE;
      a_q     <= {WIDTH{1'b0}};
      q_q     <= {WIDTH{1'b0}};
      d_q     <= {WIDTH{1'b0}};
      cnt_q   <= {CNT_W{1'b0}};
      quot_q  <= {WIDTH{1'b0}};
      rem_q   <= {WIDTH{1'b0}};
      dbz_q   <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      q_q     <= q_d;
      d_q     <= d_d;
      cnt_q   <= cnt_d;
      quot_q  <= quot_d;
      rem_q   <= rem_d;
      dbz_q   <= dbz_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign out_busy        = busy_q;
  assign out_done        = done_q;
  assign out_quotient    = quot_q;
  assign out_remainder   = rem_q;
  assign out_div_by_zero = dbz_q;

endmodule
